// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states and defaults.
// Holds the default geometry/latency and the out-of-range helper.
package dmem_responder_pkg;

    localparam int DefAddrW   = 10;
    localparam int DefWaitCyc = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // True when any byte-address bit above the word array is set.
    function automatic logic outOfRange(
        input logic [31:0] a,
        input int          aw
    );
        return (a >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/dmem_responder_sram.sv
// sram_1rw_be: single-port word RAM, synchronous read, byte write enables.
// Ports: clk, ce (access), we[3:0] (lanes), a (word addr), d (wdata), q (rdata).
module sram_1rw_be #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          ce,
    input  logic [3:0]    we,
    input  logic [AW-1:0] a,
    input  logic [31:0]   d,
    output logic [31:0]   q
);

    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] merged;

    // Write-first: q returns the word as it stands after this access.
    always_comb begin
        merged = mem[a];
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                merged[8*b +: 8] = d[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            if (|we) begin
                mem[a] <= merged;
            end
            q <= merged;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state FSM in front of a byte-enabled SRAM.
// Ports: clk, rst (sync, low), en/wen/addr/wdata in; rdata/stall/data_ok/err out.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W   = DefAddrW,
    parameter int WAIT_CYC = DefWaitCyc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        data_ok,
    output logic        err
);

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYC);

    state_t            state;
    state_t            stateNext;
    logic [3:0]        waitCnt;
    logic [ADDR_W-1:0] capAddr;
    logic [3:0]        capWen;
    logic [31:0]       capWdata;
    logic              capErr;
    logic [31:0]       rdataQ;
    logic [31:0]       memQ;
    logic              memCe;
    logic [3:0]        memWe;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            waitCnt  <= '0;
            capAddr  <= '0;
            capWen   <= '0;
            capWdata <= '0;
            capErr   <= 1'b0;
            rdataQ   <= '0;
        end else begin
            state <= stateNext;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        capAddr  <= addr[ADDR_W+1:2];
                        capWen   <= wen;
                        capWdata <= wdata;
                        capErr   <= outOfRange(addr, ADDR_W);
                        waitCnt  <= WaitLoad;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                end
                RESP: begin
                    // Keep the response visible after data_ok falls.
                    rdataQ <= rdata;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        memCe     = 1'b0;
        memWe     = 4'b0000;
        stall     = 1'b0;
        data_ok   = 1'b0;
        err       = 1'b0;
        rdata     = rdataQ;
        unique case (state)
            IDLE: begin
                if (en) begin
                    stall     = 1'b1;
                    stateNext = (WaitLoad == 4'd0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (waitCnt <= 4'd1) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                stall     = 1'b1;
                memCe     = ~capErr;
                memWe     = capErr ? 4'b0000 : capWen;
                stateNext = RESP;
            end
            RESP: begin
                data_ok   = 1'b1;
                err       = capErr;
                rdata     = capErr ? 32'h0 : memQ;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        // Nothing may issue or be requested while reset is held.
        if (!rst) begin
            memCe   = 1'b0;
            memWe   = 4'b0000;
            stall   = 1'b0;
            data_ok = 1'b0;
            err     = 1'b0;
        end
    end

    sram_1rw_be #(
        .AW(ADDR_W)
    ) uSram (
        .clk(clk),
        .ce (memCe),
        .we (memWe),
        .a  (capAddr),
        .d  (capWdata),
        .q  (memQ)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_CYC=2 and WAIT_CYC=0 instances).
// Expected values are hand-computed constants.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        en0;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] rdata0;
    logic        stall;
    logic        stall0;
    logic        data_ok;
    logic        dataOk0;
    logic        err;
    logic        err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr),
        .wdata(wdata), .rdata(rdata), .stall(stall),
        .data_ok(data_ok), .err(err)
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .wen(wen), .addr(addr),
        .wdata(wdata), .rdata(rdata0), .stall(stall0),
        .data_ok(dataOk0), .err(err0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input bit sel, input logic [31:0] a,
                       input logic [3:0] w, input logic [31:0] d,
                       input logic [31:0] expR, input logic expE,
                       input int lat, input string tag);
        int cyc;
        logic [31:0] last;
        cyc = 0;
        if (sel) en0 = 1'b1;
        else en = 1'b1;
        addr = a;
        wen = w;
        wdata = d;
        #1;
        while (!(sel ? dataOk0 : data_ok) && cyc < 20) begin
            tick();
            cyc++;
        end
        chk(32'(cyc), 32'(lat), {tag, "_lat"});
        last = sel ? rdata0 : rdata;
        chk(last, expR, {tag, "_rdata"});
        chk({31'd0, sel ? err0 : err}, {31'd0, expE}, {tag, "_err"});
        tick();
        en = 1'b0;
        en0 = 1'b0;
        chk(sel ? rdata0 : rdata, expR, {tag, "_hold"});
    endtask

    logic [1:0] stlExp;
    int         cyc;
    int         pulses;
    int         p1;
    int         p2;
    logic [31:0] r1;
    logic [31:0] r2;

    initial begin
        rst = 1'b0;
        en = 1'b0;
        en0 = 1'b0;
        wen = 4'h0;
        addr = 32'h0;
        wdata = 32'h0;
        tick();
        tick();
        chk(rdata, 32'h0, "rst_rdata");
        chk({31'd0, data_ok}, 32'd0, "rst_dok");
        chk({31'd0, err}, 32'd0, "rst_err");
        chk({31'd0, stall}, 32'd0, "rst_stall");
        chk(rdata0, 32'h0, "rst_rdata0");
        rst = 1'b1;
        tick();

        req(0, 32'h10, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 4, "wr10");
        req(0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 0, 4, "rd10");
        req(0, 32'h20, 4'hF, 32'h11223344, 32'h11223344, 0, 4, "pre20");
        req(0, 32'h20, 4'b0010, 32'h0000AA00, 32'h1122AA44, 0, 4, "wrb20");
        req(0, 32'h20, 4'h0, 32'h0, 32'h1122AA44, 0, 4, "rd20");

        // Stall profile, WAIT_CYC=2: 1 for T..T+3, 0 at T+4.
        en = 1'b1;
        addr = 32'h10;
        wen = 4'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            stlExp = (i < 4) ? 2'b10 : 2'b01;
            chk({30'd0, stall, data_ok}, {30'd0, stlExp}, "stl2");
            tick();
        end
        en = 1'b0;

        req(1, 32'h40, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, 0, 2, "wr40w0");
        req(1, 32'h40, 4'h0, 32'h0, 32'hCAFEF00D, 0, 2, "rd40w0");

        // Stall profile, WAIT_CYC=0: 1 for T..T+1, data_ok at T+2.
        en0 = 1'b1;
        addr = 32'h40;
        wen = 4'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            stlExp = (i < 2) ? 2'b10 : 2'b01;
            chk({30'd0, stall0, dataOk0}, {30'd0, stlExp}, "stl0");
            tick();
        end
        en0 = 1'b0;

        req(0, 32'h0, 4'hF, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 4, "wr0");
        req(0, 32'h1000, 4'h0, 32'h0, 32'h0, 1, 4, "oorRd");
        req(0, 32'h1000, 4'hF, 32'h12345678, 32'h0, 1, 4, "oorWr");
        req(0, 32'h0, 4'h0, 32'h0, 32'hA5A5A5A5, 0, 4, "rd0");

        // Inputs change and en drops after capture.
        en = 1'b1;
        addr = 32'h50;
        wen = 4'hF;
        wdata = 32'h01020304;
        tick();
        en = 1'b0;
        addr = 32'h10;
        wen = 4'h0;
        wdata = 32'hFFFFFFFF;
        cyc = 1;
        #1;
        while (!data_ok && cyc < 20) begin
            tick();
            cyc++;
        end
        chk(32'(cyc), 32'd4, "cap_lat");
        chk(rdata, 32'h01020304, "cap_rdata");
        chk({31'd0, err}, 32'd0, "cap_err");
        tick();
        req(0, 32'h50, 4'h0, 32'h0, 32'h01020304, 0, 4, "rd50");
        req(0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 0, 4, "rd10b");

        // Reset during WAIT drops the pending write.
        req(0, 32'h30, 4'hF, 32'h0BADF00D, 32'h0BADF00D, 0, 4, "pre30");
        en = 1'b1;
        addr = 32'h30;
        wen = 4'hF;
        wdata = 32'h00000055;
        tick();
        rst = 1'b0;
        en = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk(rdata, 32'h0, "mrst_rdata");
        chk({31'd0, data_ok}, 32'd0, "mrst_dok");
        chk({31'd0, err}, 32'd0, "mrst_err");
        chk({31'd0, stall}, 32'd0, "mrst_stall");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk({31'd0, data_ok}, 32'd0, "mrst_quiet");
        end
        req(0, 32'h30, 4'h0, 32'h0, 32'h0BADF00D, 0, 4, "rd30");

        // Back-to-back reads with en held through RESP.
        en = 1'b1;
        addr = 32'h10;
        wen = 4'h0;
        pulses = 0;
        p1 = -1;
        p2 = -1;
        r1 = 32'h0;
        r2 = 32'h0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (data_ok) begin
                pulses++;
                if (pulses == 1) begin
                    p1 = i;
                    r1 = rdata;
                end else if (pulses == 2) begin
                    p2 = i;
                    r2 = rdata;
                end
            end
            tick();
            if (pulses == 1) addr = 32'h20;
            if (pulses >= 2) en = 1'b0;
        end
        en = 1'b0;
        chk(32'(pulses), 32'd2, "b2b_pulses");
        chk(32'(p1), 32'd4, "b2b_p1");
        chk(32'(p2 - p1), 32'd5, "b2b_gap");
        chk(r1, 32'hDEADBEEF, "b2b_r1");
        chk(r2, 32'h1122AA44, "b2b_r2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
